// File: rtl/bin_to_bcd.sv
// 14-bit binary to 4-digit packed BCD converter using sequential double-dabble.
// One conversion takes 14 shift cycles; the result, the overflow flag and the
// leading-zero "show" mask are published together on the single DONE cycle.
module bin_to_bcd #(
    parameter int SAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic [3:0]  lz_mask
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [13:0] MAX_DEC   = 14'd9999;
    localparam logic [3:0]  LAST_STEP = 4'd13;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic [13:0] op_reg;
    logic [15:0] acc_reg;
    logic        ovf_pend_reg;
    logic [15:0] bcd_reg;
    logic        ovf_reg;
    logic [3:0]  lz_reg;

    logic        accept;
    logic        last_step;
    logic [15:0] adj_acc;
    logic [15:0] step_acc;
    logic [3:0]  step_lz;

    // A request is honoured only outside SHIFT; a running conversion is never disturbed.
    assign accept    = start && (state_reg != SHIFT);
    assign last_step = (state_reg == SHIFT) && (cnt_reg == LAST_STEP);

    // Per-digit "add 3 if >= 5" correction applied before every shift.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign adj_acc[4*gi+3:4*gi] = (acc_reg[4*gi+3:4*gi] >= 4'd5)
                                        ? acc_reg[4*gi+3:4*gi] + 4'd3
                                        : acc_reg[4*gi+3:4*gi];
        end
    endgenerate

    // One double-dabble step: corrected accumulator shifted left, operand MSB enters.
    assign step_acc = {adj_acc[14:0], op_reg[13]};

    // Digit k is shown when it or any more significant digit is nonzero; digit 0 always shown.
    assign step_lz[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign step_lz[gi] = |step_acc[15:4*gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: 14 edges in SHIFT, then a single DONE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == LAST_STEP) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operand on accept, shift during SHIFT, publish on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= 4'd0;
            op_reg       <= 14'd0;
            acc_reg      <= 16'h0000;
            ovf_pend_reg <= 1'b0;
            bcd_reg      <= 16'h0000;
            ovf_reg      <= 1'b0;
            lz_reg       <= 4'b0001;
        end else if (accept) begin
            // With saturation, out-of-range operands are replaced by 9999 up front.
            op_reg       <= ((bin > MAX_DEC) && (SAT != 0)) ? MAX_DEC : bin;
            ovf_pend_reg <= (bin > MAX_DEC);
            cnt_reg      <= 4'd0;
            acc_reg      <= 16'h0000;
        end else if (state_reg == SHIFT) begin
            acc_reg <= step_acc;
            op_reg  <= {op_reg[12:0], 1'b0};
            cnt_reg <= cnt_reg + 4'd1;
            if (last_step) begin
                ovf_reg <= ovf_pend_reg;
                if (ovf_pend_reg && (SAT == 0)) begin
                    bcd_reg <= 16'hEEEE;
                    lz_reg  <= 4'b1111;
                end else begin
                    bcd_reg <= step_acc;
                    lz_reg  <= step_lz;
                end
            end
        end
    end

    assign busy    = (state_reg == SHIFT);
    assign done    = (state_reg == DONE);
    assign bcd     = bcd_reg;
    assign ovf     = ovf_reg;
    assign lz_mask = lz_reg;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd. Several lanes of SAT=1 / SAT=0 instances
// run side by side so the full 14-bit operand range is swept in parallel.
module tb_bin_to_bcd;

    localparam int NL   = 8;
    localparam int SPAN = 16384 / NL;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin_l [NL];

    logic        busy1 [NL];
    logic        done1 [NL];
    logic [15:0] bcd1  [NL];
    logic        ovf1  [NL];
    logic [3:0]  lz1   [NL];
    logic        busy0 [NL];
    logic        done0 [NL];
    logic [15:0] bcd0  [NL];
    logic        ovf0  [NL];
    logic [3:0]  lz0   [NL];

    logic [15:0] prev1 [NL];
    logic [15:0] prev0 [NL];

    int total = 0;
    int bad   = 0;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            bin_to_bcd #(.SAT(1)) u_sat1 (
                .clk(clk), .rst(rst), .start(start), .bin(bin_l[gi]),
                .busy(busy1[gi]), .done(done1[gi]), .bcd(bcd1[gi]),
                .ovf(ovf1[gi]), .lz_mask(lz1[gi])
            );
            bin_to_bcd #(.SAT(0)) u_sat0 (
                .clk(clk), .rst(rst), .start(start), .bin(bin_l[gi]),
                .busy(busy0[gi]), .done(done0[gi]), .bcd(bcd0[gi]),
                .ovf(ovf0[gi]), .lz_mask(lz0[gi])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    // Reference model: decimal digits by plain arithmetic.
    function automatic logic [15:0] m_bcd(input int v, input int sat);
        int n;
        if (v > 9999 && sat == 0) return 16'hEEEE;
        n = (v > 9999) ? 9999 : v;
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [3:0] m_lz(input int v, input int sat);
        int n;
        if (v > 9999 && sat == 0) return 4'b1111;
        n = (v > 9999) ? 9999 : v;
        return {n >= 1000, n >= 100, n >= 10, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic set_prev_from_bins();
        for (int l = 0; l < NL; l++) begin
            prev1[l] = m_bcd(int'(bin_l[l]), 1);
            prev0[l] = m_bcd(int'(bin_l[l]), 0);
        end
    endtask

    task automatic clear_prev();
        for (int l = 0; l < NL; l++) begin
            prev1[l] = 16'h0000;
            prev0[l] = 16'h0000;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy1"}, busy1[0], 0);
        chk({tag, "_done1"}, done1[0], 0);
        chk({tag, "_bcd1"},  bcd1[0],  16'h0000);
        chk({tag, "_ovf1"},  ovf1[0],  0);
        chk({tag, "_lz1"},   lz1[0],   4'b0001);
        chk({tag, "_busy0"}, busy0[0], 0);
        chk({tag, "_bcd0"},  bcd0[0],  16'h0000);
        chk({tag, "_lz0"},   lz0[0],   4'b0001);
    endtask

    // One start pulse; waits (bounded) for done and checks latency, hold and results.
    task automatic run_conv(input string tag);
        int cur [NL];
        int lat;
        for (int l = 0; l < NL; l++) cur[l] = int'(bin_l[l]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done1[0]) break;
            chk({tag, "_hold"}, bcd1[0], prev1[0]);
            chk({tag, "_busy"}, busy1[0], (lat < 14) ? 1 : 0);
        end
        chk({tag, "_lat"}, lat, 14);
        for (int l = 0; l < NL; l++) begin
            chk({tag, "_done1"}, done1[l], 1);
            chk({tag, "_done0"}, done0[l], 1);
            chk({tag, "_nbusy"}, busy1[l], 0);
            chk({tag, "_bcd1"},  bcd1[l],  m_bcd(cur[l], 1));
            chk({tag, "_bcd0"},  bcd0[l],  m_bcd(cur[l], 0));
            chk({tag, "_ovf1"},  ovf1[l],  cur[l] > 9999);
            chk({tag, "_ovf0"},  ovf0[l],  cur[l] > 9999);
            chk({tag, "_lz1"},   lz1[l],   m_lz(cur[l], 1));
            chk({tag, "_lz0"},   lz0[l],   m_lz(cur[l], 0));
            prev1[l] = m_bcd(cur[l], 1);
            prev0[l] = m_bcd(cur[l], 0);
        end
        $display("conv %s bin=%0d bcd_sat1=%h bcd_sat0=%h lz=%b ovf=%0d lat=%0d",
                 tag, cur[0], bcd1[0], bcd0[0], lz1[0], ovf1[0], lat);
    endtask

    task automatic set_all(input int v);
        for (int l = 0; l < NL; l++) bin_l[l] = 14'(v);
    endtask

    initial begin
        int np;
        int nd;
        rst   = 1'b1;
        start = 1'b0;
        set_all(0);
        clear_prev();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;

        // Zero, typical values, and hold-until-done between consecutive results.
        set_all(0);     run_conv("zero");
        set_all(1234);  run_conv("v1234");
        set_all(42);    run_conv("v42");
        set_all(9999);  run_conv("v9999");
        set_all(10000); run_conv("v10000");
        set_all(16383); run_conv("v16383");

        // start held high: a result every 15 cycles.
        set_all(7);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        np = 0;
        for (int e = 1; e <= 70; e++) begin
            @(posedge clk);
            #1;
            if (done1[0]) begin
                chk("held_period", e, 14 + 15 * np);
                chk("held_bcd", bcd1[0], 16'h0007);
                np++;
            end
        end
        chk("held_count", np, 4);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        set_prev_from_bins();
        $display("conv held bin=7 pulses=%0d", np);

        // Random extra start pulses while busy produce no extra result.
        set_all(321);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done1[0]) nd++;
            start = (c >= 1 && c <= 9) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        chk("busy_starts_done", nd, 1);
        chk("busy_starts_bcd", bcd1[0], 16'h0321);
        set_prev_from_bins();
        $display("conv busy_starts bin=321 dones=%0d", nd);

        // Reset on the 7th SHIFT cycle aborts the conversion.
        set_all(5678);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("abort");
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done1[0] || done0[0]) nd++;
            chk("abort_bcd_hold", bcd1[0], 16'h0000);
        end
        chk("abort_no_done", nd, 0);
        clear_prev();
        $display("conv abort bin=5678 dones=%0d", nd);
        run_conv("after_rst");

        // Exhaustive sweep, lanes cover disjoint slices of the range.
        for (int i = 0; i < SPAN; i++) begin
            for (int l = 0; l < NL; l++) bin_l[l] = 14'(l * SPAN + i);
            run_conv("sweep");
        end

        // Random operands with random idle gaps.
        for (int r = 0; r < 100; r++) begin
            for (int l = 0; l < NL; l++) bin_l[l] = 14'($urandom_range(0, 16383));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_conv("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
